// File: rtl/poly_add_ctrl.sv
// ============================================================================
// Module   : poly_add_ctrl
// Purpose  : Sequences one full polynomial addition through the coefficient
//            adder: reads N operand pairs, writes N reduced results, pulses done.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module poly_add_ctrl #(
   parameter int N        = 1024,
   parameter int ADDR_W   = 10,
   parameter int PIPE_LAT = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              add_en,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr
);

   localparam int c_flush_w = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
   localparam logic [ADDR_W-1:0]    c_last_addr  = ADDR_W'(N - 1);
   localparam logic [c_flush_w-1:0] c_last_flush = c_flush_w'(PIPE_LAT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_FLUSH = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [ADDR_W-1:0]      r_cnt;
   logic [ADDR_W-1:0]      w_cnt_nxt;
   logic [c_flush_w-1:0]   r_fcnt;
   logic [c_flush_w-1:0]   w_fcnt_nxt;

   // Delay lines that line up each read with its result leaving the adder.
   logic [PIPE_LAT-1:0]             r_vld_pipe;
   logic [PIPE_LAT-1:0][ADDR_W-1:0] r_addr_pipe;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_fcnt  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_fcnt  <= w_fcnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_fcnt_nxt  = r_fcnt;
      rd_en       = 1'b0;
      add_en      = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = S_READ;
               w_cnt_nxt   = '0;
               w_fcnt_nxt  = '0;
            end
         end
         S_READ: begin
            rd_en  = 1'b1;
            add_en = 1'b1;
            busy   = 1'b1;
            if (r_cnt == c_last_addr) begin
               w_state_nxt = S_FLUSH;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt   = r_cnt + 1'b1;
            end
         end
         S_FLUSH: begin
            add_en = 1'b1;
            busy   = 1'b1;
            if (r_fcnt == c_last_flush) begin
               w_state_nxt = S_DONE;
               w_fcnt_nxt  = '0;
            end else begin
               w_fcnt_nxt  = r_fcnt + 1'b1;
            end
         end
         S_DONE: begin
            done        = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign rd_addr = r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld_pipe  <= '0;
         r_addr_pipe <= '0;
      end else begin
         r_vld_pipe[0]  <= rd_en;
         r_addr_pipe[0] <= r_cnt;
         for (int i = 1; i < PIPE_LAT; i++) begin
            r_vld_pipe[i]  <= r_vld_pipe[i-1];
            r_addr_pipe[i] <= r_addr_pipe[i-1];
         end
      end
   end

   assign wr_en   = r_vld_pipe[PIPE_LAT-1];
   assign wr_addr = r_addr_pipe[PIPE_LAT-1];

endmodule

`default_nettype wire

// File: tb/tb_poly_add_ctrl.sv
// ============================================================================
// Module   : tb_poly_add_ctrl
// Purpose  : Self-checking bench for poly_add_ctrl with BRAM and adder models.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_poly_add_ctrl;

   localparam int N   = 1024;
   localparam int AW  = 10;
   localparam int PL  = 3;
   localparam int Q   = 12289;
   localparam int RUN = N + PL + 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic          busy, done, rd_en, add_en, wr_en;
   logic [AW-1:0] rd_addr, wr_addr;

   always #5 clk = ~clk;

   poly_add_ctrl #(.N(N), .ADDR_W(AW), .PIPE_LAT(PL)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .busy    (busy),
      .done    (done),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .add_en  (add_en),
      .wr_en   (wr_en),
      .wr_addr (wr_addr)
   );

   // Operand BRAMs, two-stage modular adder and result BRAM around the DUT.
   int   mem_a [N];
   int   mem_b [N];
   int   res   [N];
   int   wcnt  [N];
   int   da, db, sum_r, out_r;
   logic clr = 1'b0;

   always @(posedge clk) begin
      if (rd_en) begin
         da <= mem_a[rd_addr];
         db <= mem_b[rd_addr];
      end
      if (add_en) begin
         sum_r <= da + db;
         out_r <= (sum_r >= Q) ? sum_r - Q : sum_r;
      end
      if (clr) begin
         for (int i = 0; i < N; i++) begin
            wcnt[i] <= 0;
            res[i]  <= -1;
         end
      end else if (wr_en) begin
         res[wr_addr]  <= out_r;
         wcnt[wr_addr] <= wcnt[wr_addr] + 1;
      end
   end

   // Reference: m_t counts cycles since the accepted start edge (-1 when idle).
   int m_t    = -1;
   int m_runs = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_t <= -1;
      end else if (m_t == -1) begin
         if (start) m_t <= 1;
      end else if (m_t == N + PL + 1) begin
         m_t    <= -1;
         m_runs <= m_runs + 1;
      end else begin
         m_t <= m_t + 1;
      end
   end

   int n_chk  = 0;
   int n_err  = 0;
   int n_done = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      int e_busy, e_rd, e_wr, e_done;
      @(negedge clk);
      if (done) n_done++;
      e_busy = (m_t >= 1 && m_t <= N + PL) ? 1 : 0;
      e_rd   = (m_t >= 1 && m_t <= N) ? 1 : 0;
      e_wr   = (m_t >= PL + 1 && m_t <= N + PL) ? 1 : 0;
      e_done = (m_t == N + PL + 1) ? 1 : 0;
      chk("busy",   int'(busy),   e_busy);
      chk("done",   int'(done),   e_done);
      chk("rd_en",  int'(rd_en),  e_rd);
      chk("add_en", int'(add_en), e_busy);
      chk("wr_en",  int'(wr_en),  e_wr);
      if (e_rd == 1) chk("rd_addr", int'(rd_addr), m_t - 1);
      if (e_wr == 1) chk("wr_addr", int'(wr_addr), m_t - 1 - PL);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic clear();
      clr = 1'b1;
      tick();
      clr    = 1'b0;
      n_done = 0;
   endtask

   task automatic wait_idle();
      int k = 0;
      while (!(m_t == -1 && !busy) && k < 3 * RUN) begin
         tick();
         k++;
      end
      chk("wait_idle", (m_t == -1 && !busy) ? 1 : 0, 1);
   endtask

   task automatic check_mem(input string nm, input int runs);
      int nbad = 0;
      int nw   = 0;
      for (int i = 0; i < N; i++) begin
         if (res[i] != (mem_a[i] + mem_b[i]) % Q) nbad++;
         if (wcnt[i] != runs) nw++;
      end
      chk({nm, "_data_bad"}, nbad, 0);
      chk({nm, "_wcount_bad"}, nw, 0);
   endtask

   typedef struct {
      int off;
      int busy, done, rd, add, wr;
      int rda, wra;   // -1 = not checked
   } vec_t;

   vec_t vt [8];

   initial begin
      int r0, runs;

      vt[0] = '{1,          1, 0, 1, 1, 0, 0,     -1};
      vt[1] = '{2,          1, 0, 1, 1, 0, 1,     -1};
      vt[2] = '{PL + 1,     1, 0, 1, 1, 1, PL,    0};
      vt[3] = '{N,          1, 0, 1, 1, 1, N - 1, N - 1 - PL};
      vt[4] = '{N + 1,      1, 0, 0, 1, 1, -1,    N - PL};
      vt[5] = '{N + PL,     1, 0, 0, 1, 1, -1,    N - 1};
      vt[6] = '{N + PL + 1, 0, 1, 0, 0, 0, -1,    -1};
      vt[7] = '{N + PL + 2, 0, 0, 0, 0, 0, -1,    -1};

      rst_n = 1'b0;
      start = 1'b0;
      for (int i = 0; i < N; i++) begin
         mem_a[i] = 12288;
         mem_b[i] = 12288;
      end
      repeat (3) tick();
      chk("rst_busy",    int'(busy),    0);
      chk("rst_done",    int'(done),    0);
      chk("rst_rd_en",   int'(rd_en),   0);
      chk("rst_wr_en",   int'(wr_en),   0);
      chk("rst_rd_addr", int'(rd_addr), 0);
      chk("rst_wr_addr", int'(wr_addr), 0);
      rst_n = 1'b1;

      repeat (100) tick();
      chk("idle_done_count", n_done, 0);

      // Cycle-exact table around a single run, a = b = 12288.
      clear();
      start = 1'b1;
      for (int off = 1; off <= N + PL + 2; off++) begin
         tick();
         if (off == 1) start = 1'b0;
         for (int j = 0; j < 8; j++) begin
            if (vt[j].off == off) begin
               chk("tbl_busy",   int'(busy),   vt[j].busy);
               chk("tbl_done",   int'(done),   vt[j].done);
               chk("tbl_rd_en",  int'(rd_en),  vt[j].rd);
               chk("tbl_add_en", int'(add_en), vt[j].add);
               chk("tbl_wr_en",  int'(wr_en),  vt[j].wr);
               if (vt[j].rda >= 0) chk("tbl_rd_addr", int'(rd_addr), vt[j].rda);
               if (vt[j].wra >= 0) chk("tbl_wr_addr", int'(wr_addr), vt[j].wra);
            end
         end
      end
      wait_idle();
      chk("max_done_count", n_done, 1);
      chk("max_res0", res[0], 12287);
      check_mem("max", 1);

      // a = 12288, b = 1 wraps to 0.
      for (int i = 0; i < N; i++) mem_b[i] = 1;
      clear();
      pulse_start();
      wait_idle();
      chk("wrap_res_last", res[N-1], 0);
      check_mem("wrap", 1);

      // a = i, b = 0 passes through.
      for (int i = 0; i < N; i++) begin
         mem_a[i] = i;
         mem_b[i] = 0;
      end
      clear();
      pulse_start();
      wait_idle();
      chk("ident_res777", res[777], 777);
      check_mem("ident", 1);

      // start held high: three back-to-back runs.
      clear();
      start = 1'b1;
      repeat (2 * RUN + 1) tick();
      start = 1'b0;
      wait_idle();
      chk("held_done_count", n_done, 3);
      check_mem("held", 3);

      // start mid-READ and in the DONE cycle must be ignored.
      clear();
      pulse_start();
      repeat (10) tick();
      pulse_start();
      begin
         int k = 0;
         while (m_t != N + PL + 1 && k < 2 * RUN) begin
            tick();
            k++;
         end
      end
      chk("reach_done_cycle", m_t, N + PL + 1);
      chk("done_cycle_done", int'(done), 1);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      chk("ign_busy",  int'(busy),  0);
      chk("ign_rd_en", int'(rd_en), 0);
      wait_idle();
      chk("ign_done_count", n_done, 1);
      check_mem("ign", 1);

      // Asynchronous reset in cycle 500 of READ.
      clear();
      pulse_start();
      repeat (499) tick();
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy",    int'(busy),    0);
      chk("arst_done",    int'(done),    0);
      chk("arst_rd_en",   int'(rd_en),   0);
      chk("arst_add_en",  int'(add_en),  0);
      chk("arst_wr_en",   int'(wr_en),   0);
      chk("arst_rd_addr", int'(rd_addr), 0);
      chk("arst_wr_addr", int'(wr_addr), 0);
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (RUN) tick();
      chk("arst_done_count", n_done, 0);
      chk("arst_no_late_write", wcnt[N-1], 0);
      clear();
      pulse_start();
      wait_idle();
      chk("post_rst_done_count", n_done, 1);
      check_mem("post_rst", 1);

      // Random operands and random start pulses.
      for (int i = 0; i < N; i++) begin
         mem_a[i] = int'($urandom_range(Q - 1));
         mem_b[i] = int'($urandom_range(Q - 1));
      end
      clear();
      r0 = m_runs;
      repeat (4000) begin
         start = ($urandom_range(15) == 0);
         tick();
      end
      start = 1'b0;
      wait_idle();
      runs = m_runs - r0;
      chk("rand_done_count", n_done, runs);
      if (runs > 0) check_mem("rand", runs);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/poly_add_ctrl.md
Name: poly_add_ctrl

Overview:
- Sequencer for one full polynomial addition through the registered coefficient adder (2-stage: sum register, then reduced-output register, both gated by its enable).
- On a start pulse it streams N coefficient-pair read addresses to the two operand BRAMs (1-cycle read latency) and drives the adder enable.
- It writes each reduced result back to the result BRAM at the matching address, then pulses done.
- Sits between the NewHope top-level control FSM and the poly memories/adder.

Parameters:
- N, 1024, coefficients per polynomial (power of two, >= 4).
- ADDR_W, 10, address width, log2(N).
- PIPE_LAT, 3, cycles from rd_addr presented to result valid at the adder output (1 BRAM + 2 adder).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request; accepted only in IDLE.
- busy  output  1  high from the cycle after start is accepted until the DONE cycle, exclusive.
- done  output  1  one-cycle completion pulse.
- rd_en  output  1  operand BRAM read enable (both ports).
- rd_addr  output  ADDR_W  operand BRAM read address.
- add_en  output  1  enable to the coefficient adder.
- wr_en  output  1  result BRAM write enable.
- wr_addr  output  ADDR_W  result BRAM write address.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy, done, rd_en, add_en, wr_en = 0; rd_addr, wr_addr = 0; valid/address delay lines cleared. Reset mid-run abandons the run: no further writes, no done.
- All outputs are registered or decoded from registered state; none depend combinationally on start.
- States: IDLE, READ, FLUSH, DONE.
- IDLE: start=1 -> READ; read counter cnt=0, flush counter=0.
- READ (N cycles):
  - rd_en=1, rd_addr=cnt, add_en=1, busy=1.
  - cnt increments each cycle; when cnt==N-1 -> FLUSH (cnt wraps to 0, unused).
- FLUSH (PIPE_LAT cycles): rd_en=0, add_en=1, busy=1; flush counter reaches PIPE_LAT-1 -> DONE.
- DONE (1 cycle): done=1, busy=0, add_en=0, rd_en=0 -> IDLE.
- Write tracking:
  - PIPE_LAT-deep shift registers carry rd_en and rd_addr.
  - wr_en = rd_en delayed PIPE_LAT cycles; wr_addr = rd_addr delayed PIPE_LAT cycles.
  - Exactly N writes, addresses 0..N-1 ascending, contiguous, the last one in the final FLUSH cycle.
- Latency: start accepted at edge k; first rd_en in cycle k+1; first wr_en in cycle k+1+PIPE_LAT; done in cycle k+N+PIPE_LAT+1. busy is high for exactly N+PIPE_LAT cycles.
- start while busy or in DONE is ignored (not queued). A new start may be accepted in the first IDLE cycle after DONE.
- Data never passes through this block; result reduction to [0, q) is performed by the adder.

Test Plan:
- N=4, single start at edge k -> rd_addr 0,1,2,3 in cycles k+1..k+4; wr_en with wr_addr 0..3 in cycles k+4..k+7; done=1 only in cycle k+8; busy high k+1..k+7.
- N=1024 full run with BRAM and adder models, a[i]=12288, b[i]=12288 -> every result 12287; a[i]=12288, b[i]=1 -> 0; a[i]=i, b[i]=0 -> i. Exactly 1024 writes, no duplicate or missing address.
- start held high continuously -> runs back-to-back separated by exactly one DONE and one IDLE cycle; no extra done pulses.
- start pulsed mid-READ and in the DONE cycle -> ignored; write count per run stays N.
- rst_n low at cycle 500 of READ -> all outputs 0 immediately (asynchronous); no done; a following start runs a complete, correct N-coefficient pass.
- Idle with start=0 for 100 cycles after reset -> rd_en, add_en, wr_en, done, busy all constant 0.
